// File: rtl/tinyproc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tinyproc_pkg                                           |
// | Description : Shared constants and loader state encoding for the     |
// |               accumulator CPU program-loader slice.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package tinyproc_pkg;

    localparam int         c_addr_width_def  = 8;
    localparam int         c_instr_width_def = 10;
    localparam logic [7:0] c_sync_byte       = 8'hA5;

    // Loader FSM encoding, explicit 3-bit width
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        HI     = 3'd2,
        LO     = 3'd3,
        CSUM   = 3'd4,
        FINISH = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_word_asm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : prog_loader_word_asm                                   |
// | Description : Holds the upper instruction bits from the HI byte,     |
// |               joins them with the LO byte and issues one registered  |
// |               program-memory write per word. Owns the word index.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module prog_loader_word_asm #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_idx_clear,
    input  logic                   i_hi_load,
    input  logic                   i_lo_load,
    input  logic [7:0]             i_byte,
    output logic [ADDR_WIDTH-1:0]  o_word_idx,
    output logic                   o_mem_we,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [INSTR_WIDTH-1:0] o_mem_wdata
);

    localparam int c_hi_w = INSTR_WIDTH - 8;

    logic [c_hi_w-1:0]      r_hi;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [INSTR_WIDTH-1:0] r_wdata;

    // Capture HI bits, advance index and launch the write one cycle after LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (i_hi_load) begin
                r_hi <= i_byte[c_hi_w-1:0];
            end
            if (i_idx_clear) begin
                r_idx <= '0;
            end else if (i_lo_load) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end
            if (i_lo_load) begin
                r_we    <= 1'b1;
                r_addr  <= r_idx;
                r_wdata <= {r_hi, i_byte};
            end
        end
    end

    assign o_word_idx  = r_idx;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : prog_loader                                            |
// | Description : Byte-stream program loader. Parses a framed stream     |
// |               (SYNC, count, HI/LO word pairs, optional checksum),    |
// |               writes program memory and releases the CPU on success. |
// |               Optional feature macro: PROG_LOADER_CHECKSUM_EN        |
// |               (adds the trailing checksum byte and its check).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module prog_loader
    import tinyproc_pkg::*;
#(
    parameter int         ADDR_WIDTH  = c_addr_width_def,
    parameter int         INSTR_WIDTH = c_instr_width_def,
    parameter logic [7:0] SYNC_BYTE   = c_sync_byte
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   load_error
);

    // HI byte bits that may legally be set (upper INSTR_WIDTH-8 bits of a word)
    localparam logic [7:0] c_hi_mask = 8'(8'hFF >> (16 - INSTR_WIDTH));

    loader_state_t         r_state;
    loader_state_t         w_next_state;
    logic [ADDR_WIDTH-1:0] r_count_m1;
    logic                  r_hold;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_xfer;
    logic                  w_is_sync;
    logic                  w_hi_bad;
    logic                  w_last;
    logic                  w_sync_acc;
    logic                  w_cnt_load;
    logic                  w_hi_load;
    logic                  w_lo_load;

    // Ready drops only in the one-cycle terminal states, where no byte is parsed
    assign in_ready  = (r_state != FINISH) && (r_state != ERROR);
    assign w_xfer    = in_valid && in_ready;
    assign w_is_sync = (in_data == SYNC_BYTE);
    assign w_hi_bad  = |(in_data & ~c_hi_mask);
    assign w_last    = (w_word_idx == r_count_m1);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic [7:0] w_csum_sum;

    assign w_csum_sum = r_csum + in_data;

    // Running 8-bit sum of count, payload and checksum bytes of the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if (w_sync_acc) begin
            r_csum <= 8'h00;
        end else if (w_xfer && (r_state == COUNT || r_state == HI ||
                                r_state == LO    || r_state == CSUM)) begin
            r_csum <= w_csum_sum;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a SYNC value inside a frame is ordinary data
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (w_xfer && w_is_sync) w_next_state = COUNT;
            COUNT:  if (w_xfer) w_next_state = HI;
            HI:     if (w_xfer) w_next_state = w_hi_bad ? ERROR : LO;
            LO: begin
                if (w_xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next_state = w_last ? CSUM : HI;
`else
                    w_next_state = w_last ? FINISH : HI;
`endif
                end
            end
            CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (w_xfer) w_next_state = (w_csum_sum == 8'h00) ? FINISH : ERROR;
`else
                w_next_state = IDLE;
`endif
            end
            FINISH:  w_next_state = IDLE;
            ERROR:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs and datapath strobes
    always_comb begin
        w_sync_acc = (r_state == IDLE)  && w_xfer && w_is_sync;
        w_cnt_load = (r_state == COUNT) && w_xfer;
        w_hi_load  = (r_state == HI)    && w_xfer && !w_hi_bad;
        w_lo_load  = (r_state == LO)    && w_xfer;
        load_done  = (r_state == FINISH);
        cpu_hold   = r_hold && (r_state != FINISH);
        load_error = r_err || (r_state == ERROR);
    end

    // Frame bookkeeping: last word index, CPU hold and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count_m1 <= '0;
            r_hold     <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            if (w_sync_acc) begin
                r_hold <= 1'b1;
                r_err  <= 1'b0;
            end else if (r_state == FINISH) begin
                r_hold <= 1'b0;
            end else if (r_state == ERROR) begin
                r_err <= 1'b1;
            end
            // Count byte 0 wraps to all-ones, i.e. a full 2**ADDR_WIDTH image
            if (w_cnt_load) begin
                r_count_m1 <= ADDR_WIDTH'(in_data) - ADDR_WIDTH'(1);
            end
        end
    end

    prog_loader_word_asm #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_word_asm (
        .clk         (clk),
        .rst         (reset),
        .i_idx_clear (w_cnt_load),
        .i_hi_load   (w_hi_load),
        .i_lo_load   (w_lo_load),
        .i_byte      (in_data),
        .o_word_idx  (w_word_idx),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata)
    );

endmodule
`default_nettype wire
